fft_sample_loader: RTL and testbench
====================================

Name: fft_sample_loader

Overview:
- Upstream feeder for the 64-point radix-2 butterfly core.
- Accepts a serial stream of complex 16-bit samples over a valid/ready handshake and writes each sample into a parallel frame buffer at its bit-reversed index.
- When a full frame is loaded it issues a one-cycle start pulse to the core, then holds the frame stable until the core reports completion.

Parameters:
- D_WIDTH, 64, points per frame; a power of two.
- LOG_2_WIDTH, 6, log2(D_WIDTH); width of the sample counter and the bit-reverse.

Ports:
- clk  input  1  clock; all flops update on the falling edge, matching the FFT core.
- rst  input  1  asynchronous, active-high reset.
- in_Re  input  16  real part of the incoming sample.
- in_Im  input  16  imaginary part of the incoming sample.
- in_valid  input  1  sample present on in_Re/in_Im.
- in_ready  output  1  loader accepts a sample this cycle.
- flush  input  1  synchronous abort of a partial frame.
- fft_done  input  1  one-cycle pulse from the core: frame consumed, transform finished.
- out_Re  output  16 x D_WIDTH  frame buffer, real parts, bit-reversed order.
- out_Im  output  16 x D_WIDTH  frame buffer, imaginary parts, bit-reversed order.
- start  output  1  one-cycle pulse: frame complete and stable.
- busy  output  1  frame handed to the core; waiting for fft_done.
- fill_count  output  LOG_2_WIDTH  samples accepted so far in the current frame.
- frame_count  output  8  frames issued since reset; wraps 255 -> 0.

Behaviour:
- Reset, asynchronous, while rst=1:
  - state=FILL; fill_count=0; frame_count=0.
  - Every out_Re/out_Im entry = 0.
  - start=0, busy=0, in_ready=1.
- Handshake: a sample is accepted on a falling edge where in_valid=1 and in_ready=1.
- in_ready is combinational from state only: 1 in FILL, else 0. It never depends on in_valid.
- Write address is bitrev(fill_count) over LOG_2_WIDTH bits, e.g. 1->32, 3->48, 6->24, 63->63.
- Only the addressed entry changes; all other entries hold.
- State FILL:
  - On accept: write the entry; fill_count++.
  - If fill_count was D_WIDTH-1: fill_count wraps to 0 and next state is START.
  - flush=1: fill_count<=0, stay in FILL, and a sample offered that cycle is dropped (flush wins). Buffer contents are not cleared.
  - fft_done is ignored.
- State START (exactly one cycle):
  - start=1, in_ready=0, busy=0.
  - frame_count++ on the edge leaving START; next state is BUSY unconditionally.
  - flush and fft_done are ignored.
- State BUSY:
  - busy=1, in_ready=0; the buffer is frozen.
  - fft_done=1: next state is FILL and fill_count=0.
  - flush is ignored in BUSY.
- start and busy are registered state decodes, so they are glitch-free.
- Latency:
  - The start pulse appears in the cycle after the edge that accepted sample D_WIDTH-1.
  - in_ready returns in the cycle after the edge that samples fft_done=1.
  - Minimum frame period is D_WIDTH + 2 cycles plus the core's processing time.
- Data path: pass-through only, no scaling or arithmetic; 16-bit values are stored verbatim.
- Reset mid-operation (any state): asynchronous return to the reset values above; the partial frame is lost.
- Stable in_valid=1 with in_Re changing each cycle in FILL: one sample is accepted per cycle with no bubbles.

Test Plan:
- Reset, then stream samples k=0..63 with in_Re=k, in_Im=100+k back-to-back -> start high for exactly one cycle, one cycle after sample 63 is accepted. Checks at that cycle:
  - out_Re[32]=1, out_Re[48]=3, out_Re[24]=6, out_Re[0]=0, out_Re[63]=63.
  - out_Im[32]=101.
  - frame_count 0->1.
- During BUSY, hold in_valid=1 with changing data for 20 cycles -> in_ready=0 and the buffer unchanged. Pulse fft_done -> next cycle in_ready=1, busy=0, fill_count=0.
- Send 10 samples, assert flush together with the 11th in_valid -> fill_count=0 and the 11th sample dropped. A following 64-sample frame gives start after exactly 64 accepts.
- In_valid gapped (1 of every 3 cycles) -> fill_count increments only on accepts, and start is still issued after the 64th accept.
- Assert rst while in BUSY and again at fill_count=40 -> immediate return to the reset values, every out entry 0, frame_count=0.
- Run 256 frames with fft_done returned 5 cycles after each start -> frame_count wraps to 0 after frame 256, and fft_done pulses in FILL have no effect.

Source files
------------

// File: rtl/fft_sample_loader_if.sv
// rtl/fft_sample_loader_if.sv - complex sample stream into the FFT frame loader
interface fft_sample_loader_if;
  logic [15:0] in_Re;
  logic [15:0] in_Im;
  logic        in_valid;
  logic        in_ready;

  modport master (
    output in_Re,
    output in_Im,
    output in_valid,
    input  in_ready
  );

  modport slave (
    input  in_Re,
    input  in_Im,
    input  in_valid,
    output in_ready
  );
endinterface

// File: rtl/fft_sample_loader.sv
// rtl/fft_sample_loader.sv - loads a bit-reversed frame and hands it to the FFT core
module fft_sample_loader #(
  parameter int D_WIDTH     = 64,
  parameter int LOG_2_WIDTH = 6
) (
  input  logic                          clk,
  input  logic                          rst,
  fft_sample_loader_if.slave            smp,
  input  logic                          flush,
  input  logic                          fft_done,
  output logic [D_WIDTH-1:0][15:0]      out_Re,
  output logic [D_WIDTH-1:0][15:0]      out_Im,
  output logic                          start,
  output logic                          busy,
  output logic [LOG_2_WIDTH-1:0]        fill_count,
  output logic [7:0]                    frame_count
);

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    START = 2'd1,
    BUSY  = 2'd2
  } state_t;

  state_t                  state;
  state_t                  next_state;
  logic                    accept;
  logic                    last_sample;
  logic [LOG_2_WIDTH-1:0]  wr_addr;

  function automatic logic [LOG_2_WIDTH-1:0] bitrev(input logic [LOG_2_WIDTH-1:0] v);
    logic [LOG_2_WIDTH-1:0] r;
    for (int i = 0; i < LOG_2_WIDTH; i++) begin
      r[i] = v[LOG_2_WIDTH-1-i];
    end
    return r;
  endfunction

  // Ready depends only on the state so upstream can never form a loop through in_valid.
  assign smp.in_ready = (state == FILL);
  // Flush wins over a sample offered in the same cycle.
  assign accept       = smp.in_valid && smp.in_ready && !flush;
  assign last_sample  = (fill_count == LOG_2_WIDTH'(D_WIDTH - 1));
  assign wr_addr      = bitrev(fill_count);

  // Next-state decode: FILL until the last sample lands, one START cycle, BUSY until the core finishes.
  always_comb begin
    next_state = state;
    case (state)
      FILL: begin
        if (accept && last_sample) begin
          next_state = START;
        end
      end
      START: begin
        next_state = BUSY;
      end
      BUSY: begin
        if (fft_done) begin
          next_state = FILL;
        end
      end
      default: begin
        next_state = FILL;
      end
    endcase
  end

  // State register; start/busy are registered from the next state so the core sees clean levels.
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      state <= FILL;
      start <= 1'b0;
      busy  <= 1'b0;
    end else begin
      state <= next_state;
      start <= (next_state == START);
      busy  <= (next_state == BUSY);
    end
  end

  // Sample and frame counters; fill_count wraps to 0 naturally on the last sample.
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      fill_count  <= '0;
      frame_count <= 8'd0;
    end else begin
      if (state == FILL && flush) begin
        fill_count <= '0;
      end else if (accept) begin
        fill_count <= fill_count + 1'b1;
      end else if (state == BUSY && fft_done) begin
        fill_count <= '0;
      end
      if (state == START) begin
        frame_count <= frame_count + 8'd1;
      end
    end
  end

  // Frame buffer: only the bit-reversed slot of the accepted sample is written.
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      out_Re <= '0;
      out_Im <= '0;
    end else if (accept) begin
      out_Re[wr_addr] <= smp.in_Re;
      out_Im[wr_addr] <= smp.in_Im;
    end
  end

endmodule

// File: tb/tb_fft_sample_loader.sv
// tb/tb_fft_sample_loader.sv - directed self-checking bench for fft_sample_loader
module tb_fft_sample_loader;
  localparam int DW = 64;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  flush;
  logic                  fft_done;
  logic [DW-1:0][15:0]   out_Re;
  logic [DW-1:0][15:0]   out_Im;
  logic                  start;
  logic                  busy;
  logic [5:0]            fill_count;
  logic [7:0]            frame_count;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] exp_re [DW];
  logic [15:0] exp_im [DW];
  logic [5:0]  m_fill;

  fft_sample_loader_if smp ();

  fft_sample_loader #(.D_WIDTH(DW), .LOG_2_WIDTH(6)) dut (
    .clk         (clk),
    .rst         (rst),
    .smp         (smp),
    .flush       (flush),
    .fft_done    (fft_done),
    .out_Re      (out_Re),
    .out_Im      (out_Im),
    .start       (start),
    .busy        (busy),
    .fill_count  (fill_count),
    .frame_count (frame_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  function automatic logic [5:0] br(input logic [5:0] v);
    return {v[0], v[1], v[2], v[3], v[4], v[5]};
  endfunction

  task automatic clear_model();
    for (int i = 0; i < DW; i++) begin
      exp_re[i] = 16'd0;
      exp_im[i] = 16'd0;
    end
    m_fill = 6'd0;
  endtask

  task automatic send(input logic [15:0] re, input logic [15:0] im);
    smp.in_valid = 1'b1;
    smp.in_Re    = re;
    smp.in_Im    = im;
    tick();
    exp_re[br(m_fill)] = re;
    exp_im[br(m_fill)] = im;
    m_fill = m_fill + 6'd1;
  endtask

  task automatic idle();
    smp.in_valid = 1'b0;
  endtask

  task automatic chk_buf(input string tag);
    int bad = 0;
    for (int i = 0; i < DW; i++) begin
      if (out_Re[i] !== exp_re[i] || out_Im[i] !== exp_im[i]) bad++;
    end
    chk(tag, bad, 0);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_fill"},  fill_count, 0);
    chk({tag, "_frame"}, frame_count, 0);
    chk({tag, "_start"}, start, 0);
    chk({tag, "_busy"},  busy, 0);
    chk({tag, "_ready"}, smp.in_ready, 1);
    chk({tag, "_buf"},   |{out_Re, out_Im}, 0);
  endtask

  task automatic done_pulse();
    smp.in_valid = 1'b0;
    fft_done     = 1'b1;
    tick();
    fft_done     = 1'b0;
  endtask

  initial begin
    rst          = 1'b1;
    flush        = 1'b0;
    fft_done     = 1'b0;
    smp.in_valid = 1'b0;
    smp.in_Re    = 16'd0;
    smp.in_Im    = 16'd0;
    clear_model();

    #3;
    chk_reset("reset");
    tick();
    tick();
    rst = 1'b0;

    // Frame 1: back-to-back samples k, 100+k.
    for (int k = 0; k < 63; k++) begin
      send(16'(k), 16'(100 + k));
      chk("f1_fill", fill_count, (k + 1) % 64);
      chk("f1_nostart", start, 0);
    end
    send(16'd63, 16'd163);
    chk("f1_start", start, 1);
    chk("f1_ready", smp.in_ready, 0);
    chk("f1_busy", busy, 0);
    chk("f1_fillwrap", fill_count, 0);
    chk("f1_frame0", frame_count, 0);
    chk("re32", out_Re[32], 1);
    chk("re48", out_Re[48], 3);
    chk("re24", out_Re[24], 6);
    chk("re0",  out_Re[0],  0);
    chk("re63", out_Re[63], 63);
    chk("im32", out_Im[32], 101);
    chk_buf("f1_buf");

    // BUSY: offered samples must be refused and the buffer frozen.
    for (int i = 0; i < 20; i++) begin
      smp.in_valid = 1'b1;
      smp.in_Re    = 16'(16'h5000 + i);
      smp.in_Im    = 16'(16'h6000 + i);
      tick();
      chk("busy_ready", smp.in_ready, 0);
      if (i == 0) begin
        chk("busy_start_low", start, 0);
        chk("busy_high", busy, 1);
        chk("frame1", frame_count, 1);
      end
    end
    chk_buf("busy_buf");
    done_pulse();
    chk("done_ready", smp.in_ready, 1);
    chk("done_busy", busy, 0);
    chk("done_fill", fill_count, 0);

    // Flush after 10 samples drops the 11th and leaves the buffer alone.
    for (int k = 0; k < 10; k++) send(16'(200 + k), 16'(250 + k));
    chk("pre_flush_fill", fill_count, 10);
    flush        = 1'b1;
    smp.in_valid = 1'b1;
    smp.in_Re    = 16'd999;
    smp.in_Im    = 16'd999;
    tick();
    flush = 1'b0;
    idle();
    chk("flush_fill", fill_count, 0);
    chk("flush_ready", smp.in_ready, 1);
    chk("flush_re20", out_Re[20], 10);
    chk_buf("flush_buf");
    m_fill = 6'd0;
    for (int k = 0; k < 64; k++) begin
      send(16'(300 + k), 16'(700 + k));
      chk("f2_start", start, (k == 63) ? 1 : 0);
    end
    chk_buf("f2_buf");
    idle();
    tick();
    chk("f2_busy", busy, 1);
    chk("frame2", frame_count, 2);
    done_pulse();

    // Gapped stream: one valid cycle in three.
    for (int k = 0; k < 64; k++) begin
      send(16'(400 + k), 16'(800 + k));
      chk("gap_fill", fill_count, (k + 1) % 64);
      chk("gap_start", start, (k == 63) ? 1 : 0);
      if (k < 63) begin
        idle();
        tick();
        tick();
        chk("gap_hold", fill_count, k + 1);
      end
    end
    idle();
    chk_buf("gap_buf");
    tick();
    chk("gap_busy", busy, 1);
    chk("frame3", frame_count, 3);

    // Asynchronous reset while BUSY, then again at fill_count=40.
    #2 rst = 1'b1;
    #1;
    chk_reset("rst_busy");
    tick();
    rst = 1'b0;
    clear_model();
    for (int k = 0; k < 40; k++) send(16'(k + 1), 16'(k + 2));
    chk("fill40", fill_count, 40);
    idle();
    #2 rst = 1'b1;
    #1;
    chk_reset("rst_fill40");
    tick();
    rst = 1'b0;
    clear_model();

    // 256 frames: frame_count wrap, fft_done ignored while filling.
    for (int f = 0; f < 256; f++) begin
      for (int k = 0; k < 64; k++) begin
        fft_done = (k == 30);
        send(16'(f + k), 16'(f ^ k));
        fft_done = 1'b0;
        if (k == 30) begin
          chk("fill_done_ignored", fill_count, 31);
          chk("fill_done_ready", smp.in_ready, 1);
        end
      end
      chk("wrap_start", start, 1);
      idle();
      for (int c = 0; c < 4; c++) tick();
      done_pulse();
      chk("wrap_ready", smp.in_ready, 1);
      if (f == 0)   chk("wrap_frame1", frame_count, 1);
      if (f == 254) chk("wrap_frame255", frame_count, 255);
      if (f == 255) chk("wrap_frame0", frame_count, 0);
    end
    chk_buf("wrap_buf");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
